// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a runtime-programmable pattern, length and overlap mode.
// Optional saturating match counter (match_cnt, cnt_clr) is built when MATCH_CNT_EN is defined.
module seq_pattern_detector #(
    parameter int               PAT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = 8'h0B,
    parameter int               DEF_LEN = 4,
    parameter int               DEF_OVL = 1
`ifdef MATCH_CNT_EN
    ,
    parameter int               CNT_W   = 8
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pat,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_overlap,
    input  logic                         in_valid,
    input  logic                         in,
    output logic                         match
`ifdef MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]             match_cnt,
    input  logic                         cnt_clr
`endif
);

    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_next;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_inc;
    logic             ovl;
    logic             hit;

    function automatic logic [LEN_W-1:0] sat_fill(input logic [LEN_W-1:0] f);
        return (f >= MAX_LEN) ? f : f + 1'b1;
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    // Ones in the low l bit positions: selects the active part of the pattern.
    function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] l);
        logic [PAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < PAT_W; i++) begin
            m[i] = (i < int'(l));
        end
        return m;
    endfunction

    always_comb begin
        hist_next = (hist << 1) | {{(PAT_W-1){1'b0}}, in};
        fill_inc  = sat_fill(fill);
        hit       = in_valid && !cfg_load && (len != '0) && (fill_inc >= len) &&
                    (((hist_next ^ pat) & len_mask(len)) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
            pat   <= DEF_PAT;
            len   <= LEN_W'(DEF_LEN);
            ovl   <= (DEF_OVL != 0);
        end else begin
            match <= hit;
            if (cfg_load) begin
                pat  <= cfg_pat;
                len  <= clamp_len(cfg_len);
                ovl  <= cfg_overlap;
                hist <= '0;
                fill <= '0;
            end else if (in_valid) begin
                hist <= hist_next;
                // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
                fill <= (hit && !ovl) ? '0 : fill_inc;
            end
        end
    end

`ifdef MATCH_CNT_EN
    function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    // Counts on the same edge that registers the match pulse; clear wins over a coincident match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (hit) begin
            match_cnt <= sat_cnt(match_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: a sample-queue model predicts each
// registered match (and counter value when MATCH_CNT_EN is defined).
module tb_seq_pattern_detector;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_load;
    logic [7:0] cfg_pat;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       in_valid;
    logic       din;
    logic       match;
`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_clr;
`endif

    seq_pattern_detector #(
        .PAT_W(8), .DEF_PAT(8'h0B), .DEF_LEN(4), .DEF_OVL(1)
`ifdef MATCH_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in(din), .match(match)
`ifdef MATCH_CNT_EN
        , .match_cnt(match_cnt), .cnt_clr(cnt_clr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit m;
        int c;
    } exp_t;

    exp_t       sbq[$];
    bit         samp[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_cnt;
    int         n_chk  = 0;
    int         n_pass = 0;
    int         pulses = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic drain_one();
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_val("match", int'(match), int'(e.m));
            if (match) pulses++;
`ifdef MATCH_CNT_EN
            check_val("match_cnt", int'(match_cnt), e.c);
`endif
        end
    endtask

    task automatic model_defaults();
        m_pat = 8'h0B;
        m_len = 4;
        m_ovl = 1'b1;
        m_cnt = 0;
        samp.delete();
    endtask

    // Keeps the samples seen since the last clear; compares the newest m_len against the pattern.
    task automatic model_sample(input bit b, output bit hit);
        samp.push_back(b);
        if (samp.size() > 8) void'(samp.pop_front());
        hit = 1'b0;
        if (m_len != 0 && samp.size() >= m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++)
                if (samp[samp.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 1'b0;
        end
        if (hit && !m_ovl) samp.delete();
    endtask

    task automatic step(input bit v, input bit b, input bit clr);
        exp_t e;
        bit   h;
        @(negedge clk);
        drain_one();
        cfg_load = 1'b0;
        in_valid = v;
        din      = b;
        h = 1'b0;
        if (v) model_sample(b, h);
        e.m = h;
`ifdef MATCH_CNT_EN
        cnt_clr = clr;
        if (clr) m_cnt = 0;
        else if (h && m_cnt < CNT_MAX) m_cnt++;
`else
        if (clr) h = h;
`endif
        e.c = m_cnt;
        sbq.push_back(e);
    endtask

    task automatic send(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0);
    endtask

    task automatic flush();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] p, input int l, input bit o, input bit v, input bit b);
        exp_t e;
        @(negedge clk);
        drain_one();
        cfg_load    = 1'b1;
        cfg_pat     = p;
        cfg_len     = 4'(l);
        cfg_overlap = o;
        in_valid    = v;
        din         = b;
`ifdef MATCH_CNT_EN
        cnt_clr     = 1'b0;
`endif
        m_pat = p;
        m_len = (l > 8) ? 8 : l;
        m_ovl = o;
        samp.delete();
        e.m = 1'b0;
        e.c = m_cnt;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drain_one();
        in_valid = 1'b0;
        cfg_load = 1'b0;
        rst      = 1'b1;
        #1;
        check_val("rst_match", int'(match), 0);
`ifdef MATCH_CNT_EN
        check_val("rst_cnt", int'(match_cnt), 0);
`endif
        model_defaults();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_load = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_overlap = 1'b0;
        in_valid = 1'b0; din = 1'b0;
`ifdef MATCH_CNT_EN
        cnt_clr = 1'b0;
`endif
        model_defaults();
        repeat (2) @(negedge clk);
        check_val("reset_match", int'(match), 0);
`ifdef MATCH_CNT_EN
        check_val("reset_cnt", int'(match_cnt), 0);
`endif
        rst = 1'b0;

        // T1: default 1011 overlapping
        pulses = 0;
        send(32'b110101110101, 12);
        flush();
        check_val("t1_pulses", pulses, 1);

        // T2: 101 overlapping
        load(8'b101, 3, 1'b1, 1'b0, 1'b0);
        pulses = 0;
        send(32'b110101110101, 12);
        flush();
        check_val("t2_pulses", pulses, 4);

        // T3: 101 non-overlapping
        load(8'b101, 3, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        send(32'b110101110101, 12);
        flush();
        check_val("t3_pulses", pulses, 2);

        // T4: default cfg with an in_valid gap
        do_reset();
        pulses = 0;
        send(32'b101, 3);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        flush();
        check_val("t4_pulses", pulses, 1);

        // T5: reset mid-stream loses the partial match
        do_reset();
        pulses = 0;
        send(32'b101, 3);
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        flush();
        check_val("t5_pulses", pulses, 0);

        // Sample coincident with cfg_load is discarded
        load(8'b11, 2, 1'b1, 1'b1, 1'b1);
        pulses = 0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        flush();
        check_val("load_discard_pulses", pulses, 1);

        // Length above PAT_W clamps to 8
        load(8'hA5, 15, 1'b0, 1'b0, 1'b0);
        pulses = 0;
        send(32'b1111_0100_1010_0101, 16);
        flush();
        check_val("clamp_pulses", pulses, 1);

        // Length 0 disables the detector
        load(8'h00, 0, 1'b1, 1'b0, 1'b0);
        pulses = 0;
        send(32'h0000_0000, 10);
        flush();
        check_val("len0_pulses", pulses, 0);

        // T6: len=1 pattern 1, counter saturates, clear beats a coincident match
        load(8'h01, 1, 1'b1, 1'b0, 1'b0);
        pulses = 0;
        send(32'b111111, 6);
        flush();
        check_val("t6_pulses", pulses, 6);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        load(8'h01, 1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        flush();
        @(negedge clk);
        drain_one();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
